tlb_refill_ctrl: RTL and testbench



---
 rtl/tlb_pkg.sv | 25 ++
 rtl/tlb_refill_ctrl_if.sv | 49 ++++
 rtl/tlb_plru.sv | 86 ++++++++
 rtl/tlb_refill_ctrl.sv | 141 ++++++++++++++
 tb/tb_tlb_refill_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_pkg
// Description : Shared definitions for the L1 TLB refill path: refill FSM
//               state encodings and default geometry (entry count, VPN
//               width). Imported by the refill controller, its PLRU
//               sub-module and the attribute-update logic.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_pkg;

  localparam int TLB_ENTRIES = 8;
  localparam int TLB_VPN_W   = 27;

  // Encodings are visible on the debug 'state' port and are decoded by the
  // attribute-update logic, so the values are fixed.
  typedef enum logic [1:0] {
    READY           = 2'd0,
    REQUEST         = 2'd1,
    WAIT            = 2'd2,
    WAIT_INVALIDATE = 2'd3
  } refill_state_e;

endpackage : tlb_pkg
`default_nettype wire

// File: rtl/tlb_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_refill_ctrl_if
// Description : Lookup / hit / page-table-walk handshake bundle between the
//               TLB datapath + PTW (master side) and the refill controller
//               (slave side).
// Ports       : io_req_*      lookup miss request and idle indication
//               io_hit_*      lookup hit, feeds replacement state
//               io_ptw_*      PTW request/response/invalidate handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_refill_ctrl_if
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int VPN_W   = TLB_VPN_W,
  localparam int IDX_W  = $clog2(ENTRIES)
);

  logic             io_req_valid;
  logic             io_req_miss;
  logic [VPN_W-1:0] io_req_vpn;
  logic             io_req_ready;
  logic             io_hit_valid;
  logic [IDX_W-1:0] io_hit_idx;
  logic             io_ptw_req_valid;
  logic             io_ptw_req_ready;
  logic [VPN_W-1:0] io_ptw_req_bits_addr;
  logic             io_ptw_resp_valid;
  logic             io_ptw_invalidate;

  // TLB datapath / PTW side
  modport master (
    output io_req_valid, io_req_miss, io_req_vpn,
    output io_hit_valid, io_hit_idx,
    output io_ptw_req_ready, io_ptw_resp_valid, io_ptw_invalidate,
    input  io_req_ready, io_ptw_req_valid, io_ptw_req_bits_addr
  );

  // Refill controller side
  modport slave (
    input  io_req_valid, io_req_miss, io_req_vpn,
    input  io_hit_valid, io_hit_idx,
    input  io_ptw_req_ready, io_ptw_resp_valid, io_ptw_invalidate,
    output io_req_ready, io_ptw_req_valid, io_ptw_req_bits_addr
  );

endinterface : tlb_refill_ctrl_if
`default_nettype wire

// File: rtl/tlb_plru.sv
`default_nettype none
// ============================================================================
// Module      : tlb_plru
// Description : Tree pseudo-LRU replacement state for the L1 TLB.
//               ENTRIES-1 node bits in heap order (children of n are 2n+1
//               and 2n+2); bit=0 steers the victim to the lower-index half.
//               Two touch ports: hit is applied first, then refill.
// Ports       : clk, reset                 clock, sync active-high reset
//               hit_valid, hit_idx         touch from a lookup hit
//               refill_valid, refill_idx   touch from a committed refill
//               victim                     current PLRU victim index
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_plru
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             hit_valid,
  input  wire logic [IDX_W-1:0] hit_idx,
  input  wire logic             refill_valid,
  input  wire logic [IDX_W-1:0] refill_idx,
  output logic      [IDX_W-1:0] victim
);

  localparam int NODES = ENTRIES - 1;

  logic [NODES-1:0] tree;
  logic [NODES-1:0] tree_next;

  // Walk root-to-leaf along idx (MSB first), making each node point away
  // from the path just taken.
  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t_in,
                                             input logic [IDX_W-1:0] idx);
    logic [NODES-1:0] t;
    logic [IDX_W-1:0] path;
    logic             b;
    int               node;
    t    = t_in;
    path = idx;
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      b                    = path[IDX_W-1];
      t[node[IDX_W-1:0]]   = ~b;
      node                 = b ? (2 * node + 2) : (2 * node + 1);
      path                 = path << 1;
    end
    return t;
  endfunction

  always_comb begin
    tree_next = tree;
    if (hit_valid) begin
      tree_next = touch(tree_next, hit_idx);
    end
    if (refill_valid) begin
      tree_next = touch(tree_next, refill_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tree <= '0;
    end else begin
      tree <= tree_next;
    end
  end

  // Follow the node bits from the root; each bit becomes one index bit.
  always_comb begin
    logic d;
    int   node;
    victim = '0;
    node   = 0;
    for (int l = 0; l < IDX_W; l++) begin
      d      = tree[node[IDX_W-1:0]];
      victim = (victim << 1) | IDX_W'(d);
      node   = d ? (2 * node + 2) : (2 * node + 1);
    end
  end

endmodule : tlb_plru
`default_nettype wire

// File: rtl/tlb_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_refill_ctrl
// Description : Refill sequencer for the L1 TLB. On a lookup miss it picks a
//               victim (lowest invalid entry, else PLRU), issues the PTW
//               request, waits for the response while tracking PTW
//               invalidations, and emits a one-cycle refill strobe.
// Ports       : clk, reset       clock, sync active-high reset
//               bus (slave)      lookup / hit / PTW handshake bundle
//               valid            current entry valid vector
//               r_refill_waddr   registered victim index
//               r_refill_tag     registered miss VPN
//               refill_en        commit refill to arrays this cycle
//               state            FSM state (debug / attribute qualification)
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_refill_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int VPN_W   = TLB_VPN_W,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  wire logic               clk,
  input  wire logic               reset,
  tlb_refill_ctrl_if.slave        bus,
  input  wire logic [ENTRIES-1:0] valid,
  output logic      [IDX_W-1:0]   r_refill_waddr,
  output logic      [VPN_W-1:0]   r_refill_tag,
  output logic                    refill_en,
  output logic      [1:0]         state
);

  refill_state_e    cur_state;
  refill_state_e    next_state;
  logic             capture;
  logic [IDX_W-1:0] plru_victim;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic [IDX_W-1:0] victim;
  logic [ENTRIES-1:0] scan;

  // ---------------------------------------------------------------- victim
  // Lowest-index invalid entry; the vector is shifted so the loop index is
  // only ever used as a value, never as a bit select.
  always_comb begin
    scan       = ~valid;
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!free_found && scan[0]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
      scan = scan >> 1;
    end
  end

  assign victim = free_found ? free_idx : plru_victim;

  tlb_plru #(
    .ENTRIES (ENTRIES)
  ) u_plru (
    .clk          (clk),
    .reset        (reset),
    .hit_valid    (bus.io_hit_valid),
    .hit_idx      (bus.io_hit_idx),
    .refill_valid (refill_en),
    .refill_idx   (r_refill_waddr),
    .victim       (plru_victim)
  );

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= READY;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state           = cur_state;
    capture              = 1'b0;
    refill_en            = 1'b0;
    bus.io_req_ready     = 1'b0;
    bus.io_ptw_req_valid = 1'b0;
    case (cur_state)
      READY: begin
        bus.io_req_ready = 1'b1;
        if (bus.io_req_valid && bus.io_req_miss) begin
          capture    = 1'b1;
          next_state = REQUEST;
        end
      end
      REQUEST: begin
        bus.io_ptw_req_valid = 1'b1;
        if (bus.io_ptw_req_ready) begin
          // Accepted walk started against entries being flushed: its
          // response must be discarded.
          next_state = bus.io_ptw_invalidate ? WAIT_INVALIDATE : WAIT;
        end else if (bus.io_ptw_invalidate) begin
          next_state = READY;
        end
      end
      WAIT: begin
        if (bus.io_ptw_resp_valid) begin
          refill_en  = ~bus.io_ptw_invalidate;
          next_state = READY;
        end else if (bus.io_ptw_invalidate) begin
          next_state = WAIT_INVALIDATE;
        end
      end
      WAIT_INVALIDATE: begin
        if (bus.io_ptw_resp_valid) begin
          next_state = READY;
        end
      end
      default: begin
        next_state = READY;
      end
    endcase
  end

  // Tag and index only move when a new miss is accepted, so they stay
  // valid through the refill strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refill_waddr <= '0;
      r_refill_tag   <= '0;
    end else if (capture) begin
      r_refill_waddr <= victim;
      r_refill_tag   <= bus.io_req_vpn;
    end
  end

  assign bus.io_ptw_req_bits_addr = r_refill_tag;
  assign state                    = cur_state;

endmodule : tlb_refill_ctrl
`default_nettype wire

// File: tb/tb_tlb_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_refill_ctrl
// Description : Directed self-checking bench for tlb_refill_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_refill_ctrl;

  localparam int ENTRIES = 8;
  localparam int VPN_W   = 27;
  localparam int IDX_W   = 3;

  logic               clk;
  logic               reset;
  logic [ENTRIES-1:0] valid;
  logic [IDX_W-1:0]   r_refill_waddr;
  logic [VPN_W-1:0]   r_refill_tag;
  logic               refill_en;
  logic [1:0]         state;

  int errors = 0;
  int checks = 0;

  tlb_refill_ctrl_if #(.ENTRIES(ENTRIES), .VPN_W(VPN_W)) bus ();

  tlb_refill_ctrl #(
    .ENTRIES (ENTRIES),
    .VPN_W   (VPN_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .valid          (valid),
    .r_refill_waddr (r_refill_waddr),
    .r_refill_tag   (r_refill_tag),
    .refill_en      (refill_en),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.io_req_valid      = 1'b0;
    bus.io_req_miss       = 1'b0;
    bus.io_req_vpn        = '0;
    bus.io_hit_valid      = 1'b0;
    bus.io_hit_idx        = '0;
    bus.io_ptw_req_ready  = 1'b0;
    bus.io_ptw_resp_valid = 1'b0;
    bus.io_ptw_invalidate = 1'b0;
    valid                 = 8'hFF;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Present a miss for one cycle; leaves the controller in REQUEST.
  task automatic issue_miss(input logic [VPN_W-1:0] vpn);
    bus.io_req_valid = 1'b1;
    bus.io_req_miss  = 1'b1;
    bus.io_req_vpn   = vpn;
    tick();
    bus.io_req_valid = 1'b0;
    bus.io_req_miss  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (bus.io_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.io_req_ready); end
    checks++; if (bus.io_ptw_req_valid !== 1'b0) begin errors++; $display("FAIL reset_ptw_valid got=%b exp=0", bus.io_ptw_req_valid); end
    checks++; if (refill_en !== 1'b0) begin errors++; $display("FAIL reset_refill_en got=%b exp=0", refill_en); end
    checks++; if (r_refill_waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", r_refill_waddr); end
    checks++; if (r_refill_tag !== 27'd0) begin errors++; $display("FAIL reset_tag got=%h exp=0", r_refill_tag); end
    // A valid lookup that hits must not start a refill.
    bus.io_req_valid = 1'b1;
    tick();
    bus.io_req_valid = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL hit_lookup_state got=%0d exp=0", state); end
  endtask

  task automatic test_basic_refill();
    int pulses;
    pulses = 0;
    do_reset();
    bus.io_req_valid = 1'b1;
    bus.io_req_miss  = 1'b1;
    bus.io_req_vpn   = 27'h1234567;
    #1;
    checks++; if (bus.io_ptw_req_valid !== 1'b0) begin errors++; $display("FAIL miss_cycle_ptw_valid got=%b exp=0", bus.io_ptw_req_valid); end
    tick();
    bus.io_req_valid = 1'b0;
    bus.io_req_miss  = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_request_state got=%0d exp=1", state); end
    checks++; if (bus.io_ptw_req_valid !== 1'b1) begin errors++; $display("FAIL basic_ptw_valid got=%b exp=1", bus.io_ptw_req_valid); end
    checks++; if (r_refill_waddr !== 3'd0) begin errors++; $display("FAIL basic_waddr got=%0d exp=0", r_refill_waddr); end
    checks++; if (bus.io_ptw_req_bits_addr !== 27'h1234567) begin errors++; $display("FAIL basic_addr got=%h exp=1234567", bus.io_ptw_req_bits_addr); end
    checks++; if (bus.io_req_ready !== 1'b0) begin errors++; $display("FAIL basic_req_ready got=%b exp=0", bus.io_req_ready); end
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_wait_state got=%0d exp=2", state); end
    for (int c = 0; c < 2; c++) begin
      if (refill_en === 1'b1) pulses++;
      tick();
    end
    bus.io_ptw_resp_valid = 1'b1;
    #1;
    if (refill_en === 1'b1) pulses++;
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL basic_back_ready got=%0d exp=0", state); end
    for (int c = 0; c < 2; c++) begin
      if (refill_en === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_refill_pulses got=%0d exp=1", pulses); end
    checks++; if (r_refill_tag !== 27'h1234567) begin errors++; $display("FAIL basic_tag_held got=%h exp=1234567", r_refill_tag); end
    // Refill touched entry 0 -> nodes 0,1,3 set -> victim 4
    issue_miss(27'h0000001);
    checks++; if (r_refill_waddr !== 3'd4) begin errors++; $display("FAIL post_refill_victim got=%0d exp=4", r_refill_waddr); end
  endtask

  task automatic test_invalid_victim();
    do_reset();
    valid = 8'b1111_0111;
    issue_miss(27'h0ABCDEF);
    checks++; if (r_refill_waddr !== 3'd3) begin errors++; $display("FAIL invalid_victim got=%0d exp=3", r_refill_waddr); end
    // Invalidate without acceptance drops the request.
    bus.io_ptw_invalidate = 1'b1;
    tick();
    bus.io_ptw_invalidate = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL req_inval_state got=%0d exp=0", state); end
    checks++; if (bus.io_ptw_req_valid !== 1'b0) begin errors++; $display("FAIL req_inval_ptw_valid got=%b exp=0", bus.io_ptw_req_valid); end
  endtask

  task automatic test_plru_hits();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.io_hit_valid = 1'b1;
      bus.io_hit_idx   = IDX_W'(i);
      tick();
    end
    bus.io_hit_valid = 1'b0;
    issue_miss(27'h0000010);
    checks++; if (r_refill_waddr !== 3'd4) begin errors++; $display("FAIL plru_hits_0_3 got=%0d exp=4", r_refill_waddr); end
    bus.io_ptw_invalidate = 1'b1;
    tick();
    bus.io_ptw_invalidate = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.io_hit_valid = 1'b1;
      bus.io_hit_idx   = IDX_W'(i);
      tick();
    end
    bus.io_hit_valid = 1'b0;
    issue_miss(27'h0000020);
    checks++; if (r_refill_waddr !== 3'd0) begin errors++; $display("FAIL plru_hits_0_7 got=%0d exp=0", r_refill_waddr); end
  endtask

  task automatic test_invalidate_wait();
    do_reset();
    issue_miss(27'h7000001);
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready  = 1'b0;
    bus.io_ptw_invalidate = 1'b1;
    tick();
    bus.io_ptw_invalidate = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL wait_inval_state got=%0d exp=3", state); end
    tick();
    bus.io_ptw_resp_valid = 1'b1;
    #1;
    checks++; if (refill_en !== 1'b0) begin errors++; $display("FAIL stale_resp_refill got=%b exp=0", refill_en); end
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL stale_resp_state got=%0d exp=0", state); end
    // Accept and invalidate together also lands in WAIT_INVALIDATE.
    issue_miss(27'h7000002);
    bus.io_ptw_req_ready  = 1'b1;
    bus.io_ptw_invalidate = 1'b1;
    tick();
    bus.io_ptw_req_ready  = 1'b0;
    bus.io_ptw_invalidate = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL accept_inval_state got=%0d exp=3", state); end
    bus.io_ptw_resp_valid = 1'b1;
    tick();
    bus.io_ptw_resp_valid = 1'b0;
  endtask

  task automatic test_resp_and_inval();
    do_reset();
    issue_miss(27'h0000033);
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready  = 1'b0;
    bus.io_ptw_resp_valid = 1'b1;
    bus.io_ptw_invalidate = 1'b1;
    #1;
    checks++; if (refill_en !== 1'b0) begin errors++; $display("FAIL resp_inval_refill got=%b exp=0", refill_en); end
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    bus.io_ptw_invalidate = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL resp_inval_state got=%0d exp=0", state); end
  endtask

  task automatic test_hit_refill_same_cycle();
    do_reset();
    valid = 8'b1111_1011;
    issue_miss(27'h0000044);
    checks++; if (r_refill_waddr !== 3'd2) begin errors++; $display("FAIL same_cycle_waddr got=%0d exp=2", r_refill_waddr); end
    valid = 8'hFF;
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready  = 1'b0;
    bus.io_ptw_resp_valid = 1'b1;
    bus.io_hit_valid      = 1'b1;
    bus.io_hit_idx        = 3'd5;
    #1;
    checks++; if (refill_en !== 1'b1) begin errors++; $display("FAIL same_cycle_refill got=%b exp=1", refill_en); end
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    bus.io_hit_valid      = 1'b0;
    // touch 5 then 2: n0=1 n2=1 n6=0 -> victim 6 (reverse order gives 0)
    issue_miss(27'h0000055);
    checks++; if (r_refill_waddr !== 3'd6) begin errors++; $display("FAIL same_cycle_plru got=%0d exp=6", r_refill_waddr); end
  endtask

  task automatic test_back_to_back_stall_reset();
    do_reset();
    issue_miss(27'h5A5A5A5);
    for (int c = 0; c < 10; c++) begin
      // A response during REQUEST must be ignored.
      bus.io_ptw_resp_valid = (c == 4);
      #1;
      checks++; if (bus.io_ptw_req_valid !== 1'b1 || bus.io_ptw_req_bits_addr !== 27'h5A5A5A5 || refill_en !== 1'b0)
        begin errors++; $display("FAIL stall_cycle%0d valid=%b addr=%h refill=%b exp valid=1 addr=5a5a5a5 refill=0", c, bus.io_ptw_req_valid, bus.io_ptw_req_bits_addr, refill_en); end
      tick();
    end
    bus.io_ptw_resp_valid = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL stall_state got=%0d exp=1", state); end
    bus.io_ptw_req_ready = 1'b1;
    tick();
    bus.io_ptw_req_ready = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL stall_accept_state got=%0d exp=2", state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_in_wait got=%0d exp=0", state); end
    bus.io_ptw_resp_valid = 1'b1;
    #1;
    checks++; if (refill_en !== 1'b0) begin errors++; $display("FAIL resp_after_reset got=%b exp=0", refill_en); end
    tick();
    bus.io_ptw_resp_valid = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL resp_after_reset_state got=%0d exp=0", state); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_refill();
    test_invalid_victim();
    test_plru_hits();
    test_invalidate_wait();
    test_resp_and_inval();
    test_hit_refill_same_cycle();
    test_back_to_back_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tlb_refill_ctrl
`default_nettype wire
